// File: rtl/pipeline_ifid_skid_pkg.sv
// Shared types and defaults for the IF/ID skid stage.
//   skid_state_t : occupancy state of the one-entry skid buffer
//   ifid_entry_t : fetch entry (pc, inst, debug tag) at the default widths
//   NOP_INST_DEFAULT : addi x0,x0,0, presented when no valid entry is held
package pipeline_ifid_skid_pkg;

  localparam int PC_WIDTH   = 32;
  localparam int INST_WIDTH = 32;
  localparam int DBG_WIDTH  = 3;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } skid_state_t;

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [INST_WIDTH-1:0] inst;
    logic [DBG_WIDTH-1:0]  dbg;
  } ifid_entry_t;

endpackage

// File: rtl/pipeline_ifid_skid_buffer.sv
// Generic valid/ready register slice with a one-entry skid buffer and flush.
// up_ready comes straight from a flop, so there is no combinational path from
// dn_ready back to the upstream side.
//   clk, rst      : clock, async active-high reset
//   flush         : drop everything held and anything offered this cycle
//   up_valid/up_ready/up_data : upstream handshake and payload
//   dn_valid/dn_ready/dn_data : downstream handshake and payload (main entry)
//   occupancy     : entries held, 0..2
//
// state | meaning
// EMPTY | nothing held, main keeps its last payload
// FULL  | main holds the entry presented downstream
// SKID  | main and skid both full, upstream blocked
module pipeline_ifid_skid_buffer
  import pipeline_ifid_skid_pkg::*;
#(
  parameter int           W         = 8,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data,
  output logic [1:0]   occupancy
);

  skid_state_t  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         ready_q;
  logic         in_fire;
  logic         out_fire;

  assign in_fire  = up_valid & ready_q;
  assign out_fire = (state_q != EMPTY) & dn_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = FULL;
            main_d  = up_data;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            main_d = up_data;
          end else if (out_fire) begin
            state_d = EMPTY;
          end else if (in_fire) begin
            state_d = SKID;
            skid_d  = up_data;
          end
        end
        SKID: begin
          if (out_fire) begin
            state_d = FULL;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != SKID);
    end
  end

  assign up_ready  = ready_q;
  assign dn_valid  = (state_q != EMPTY);
  assign dn_data   = main_q;
  assign occupancy = state_q;

endmodule

// File: rtl/pipeline_ifid_skid.sv
// IF/ID stage register between fetch and decode, built on a skid buffer so
// o_Ready is registered. Decode stall acts exactly like i_Ready=0; flush
// empties the stage and wins over stall. o_Inst shows NOP_INST whenever no
// valid entry is held; o_PC keeps the last held PC.
// Optional feature macro: PIPELINE_DBG_EN adds i_DbgTag/o_DbgTag, a tag that
// travels with each entry (0 after reset and whenever no entry is valid).
//   i_Clock, i_Reset          : clock, async active-high reset
//   i_Stall, i_Flush          : decode hazard stall, redirect flush
//   i_Valid/o_Ready/i_PC/i_Inst : upstream side
//   o_Valid/i_Ready/o_PC/o_Inst : downstream side
//   o_Occupancy               : entries held, 0..2
module pipeline_ifid_skid
  import pipeline_ifid_skid_pkg::*;
#(
  parameter int                    PC_WIDTH   = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = ~PC_WIDTH'(3),
  parameter logic [INST_WIDTH-1:0] NOP_INST   = INST_WIDTH'(NOP_INST_DEFAULT),
  parameter int                    DBG_WIDTH  = 3
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Stall,
  input  logic                  i_Flush,
  input  logic                  i_Valid,
  output logic                  o_Ready,
  input  logic [PC_WIDTH-1:0]   i_PC,
  input  logic [INST_WIDTH-1:0] i_Inst,
`ifdef PIPELINE_DBG_EN
  input  logic [DBG_WIDTH-1:0]  i_DbgTag,
  output logic [DBG_WIDTH-1:0]  o_DbgTag,
`endif
  output logic                  o_Valid,
  input  logic                  i_Ready,
  output logic [PC_WIDTH-1:0]   o_PC,
  output logic [INST_WIDTH-1:0] o_Inst,
  output logic [1:0]            o_Occupancy
);

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [INST_WIDTH-1:0] inst;
`ifdef PIPELINE_DBG_EN
    logic [DBG_WIDTH-1:0]  dbg;
`endif
  } entry_t;

`ifdef PIPELINE_DBG_EN
  localparam entry_t RESET_ENTRY = '{pc: RESET_PC, inst: NOP_INST, dbg: '0};
`else
  localparam entry_t RESET_ENTRY = '{pc: RESET_PC, inst: NOP_INST};
`endif

  entry_t up_entry;
  entry_t main_entry;
  logic   dn_ready;

  assign up_entry.pc   = i_PC;
  assign up_entry.inst = i_Inst;
`ifdef PIPELINE_DBG_EN
  assign up_entry.dbg  = i_DbgTag;
`endif

  assign dn_ready = i_Ready & ~i_Stall;

  pipeline_ifid_skid_buffer #(
    .W         ($bits(entry_t)),
    .RESET_VAL (RESET_ENTRY)
  ) u_skid (
    .clk       (i_Clock),
    .rst       (i_Reset),
    .flush     (i_Flush),
    .up_valid  (i_Valid),
    .up_ready  (o_Ready),
    .up_data   (up_entry),
    .dn_valid  (o_Valid),
    .dn_ready  (dn_ready),
    .dn_data   (main_entry),
    .occupancy (o_Occupancy)
  );

  assign o_PC   = main_entry.pc;
  assign o_Inst = o_Valid ? main_entry.inst : NOP_INST;
`ifdef PIPELINE_DBG_EN
  assign o_DbgTag = o_Valid ? main_entry.dbg : '0;
`endif

endmodule

// File: tb/tb_pipeline_ifid_skid.sv
module tb_pipeline_ifid_skid;
  import pipeline_ifid_skid_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_stall = 1'b0, i_flush = 1'b0, i_valid = 1'b0, i_ready = 1'b0;
  logic [31:0] i_pc = '0, i_inst = '0;
  logic [2:0]  i_tag = '0;
  logic        o_ready, o_valid;
  logic [31:0] o_pc, o_inst;
  logic [1:0]  o_occ;
`ifdef PIPELINE_DBG_EN
  logic [2:0]  o_tag;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RPC = 32'hFFFF_FFFC;

  always #5 clk = ~clk;

  pipeline_ifid_skid dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_Stall     (i_stall),
    .i_Flush     (i_flush),
    .i_Valid     (i_valid),
    .o_Ready     (o_ready),
    .i_PC        (i_pc),
    .i_Inst      (i_inst),
`ifdef PIPELINE_DBG_EN
    .i_DbgTag    (i_tag),
    .o_DbgTag    (o_tag),
`endif
    .o_Valid     (o_valid),
    .i_Ready     (i_ready),
    .o_PC        (o_pc),
    .o_Inst      (o_inst),
    .o_Occupancy (o_occ)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[23:0], 8'h33};
  endfunction

  function automatic logic [2:0] tag_of(input logic [31:0] pc);
    return 3'(pc[4:2] + 3'd1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an ordered queue of held entries, at most two.
  ifid_entry_t mq[$];
  ifid_entry_t m_in;
  bit          m_ready = 1'b1;
  logic [31:0] m_pc    = RPC;
  bit          m_in_f, m_out_f;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mq.delete();
      m_ready = 1'b1;
      m_pc    = RPC;
    end else begin
      m_in_f  = i_valid && m_ready;
      m_out_f = (mq.size() > 0) && i_ready && !i_stall;
      m_in.pc   = i_pc;
      m_in.inst = i_inst;
      m_in.dbg  = i_tag;
      if (i_flush) begin
        mq.delete();
      end else begin
        if (m_out_f) void'(mq.pop_front());
        if (m_in_f) mq.push_back(m_in);
      end
      m_ready = (mq.size() < 2);
      if (mq.size() > 0) m_pc = mq[0].pc;
    end
  end

  always @(negedge clk) begin
    if (started && !rst) begin
      chk("model_valid", {31'd0, o_valid}, {31'd0, mq.size() > 0});
      chk("model_ready", {31'd0, o_ready}, {31'd0, m_ready});
      chk("model_occ",   {30'd0, o_occ},   32'(mq.size()));
      chk("model_pc",    o_pc, m_pc);
      chk("model_inst",  o_inst, (mq.size() > 0) ? mq[0].inst : NOP);
`ifdef PIPELINE_DBG_EN
      chk("model_tag",   {29'd0, o_tag}, (mq.size() > 0) ? {29'd0, mq[0].dbg} : 32'd0);
`endif
    end
  end

  task automatic step(input logic v, input logic [31:0] pc, input logic rdy,
                      input logic stall, input logic flush);
    i_valid = v;
    i_pc    = pc;
    i_inst  = inst_of(pc);
    i_tag   = tag_of(pc);
    i_ready = rdy;
    i_stall = stall;
    i_flush = flush;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
    chk({tag, "_ready"}, {31'd0, o_ready}, 32'd1);
    chk({tag, "_pc"},    o_pc, RPC);
    chk({tag, "_inst"},  o_inst, NOP);
    chk({tag, "_occ"},   {30'd0, o_occ}, 32'd0);
`ifdef PIPELINE_DBG_EN
    chk({tag, "_tag"},   {29'd0, o_tag}, 32'd0);
`endif
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    started = 1'b1;
    chk_reset_vals("rst_init");

    // streaming
    step(1, 32'h0, 1, 0, 0);
    chk("str0_pc", o_pc, 32'h0);
    chk("str0_inst", o_inst, 32'h0000_0033);
    step(1, 32'h4, 1, 0, 0);
    chk("str1_pc", o_pc, 32'h4);
    step(1, 32'h8, 1, 0, 0);
    chk("str2_pc", o_pc, 32'h8);
    chk("str2_ready", {31'd0, o_ready}, 32'd1);
    step(0, 32'h0, 1, 0, 0);
    chk("str_empty_valid", {31'd0, o_valid}, 32'd0);
    chk("str_empty_pc", o_pc, 32'h8);
    chk("str_empty_inst", o_inst, NOP);

    // back-pressure
    step(1, 32'h100, 0, 0, 0);
    chk("bp0_occ", {30'd0, o_occ}, 32'd1);
    step(1, 32'h104, 0, 0, 0);
    chk("bp1_occ", {30'd0, o_occ}, 32'd2);
    chk("bp1_ready", {31'd0, o_ready}, 32'd0);
    chk("bp1_pc", o_pc, 32'h100);
    step(1, 32'h108, 0, 0, 0);
    chk("bp2_occ", {30'd0, o_occ}, 32'd2);
    step(1, 32'h108, 1, 0, 0);
    chk("bp3_pc", o_pc, 32'h104);
    chk("bp3_ready", {31'd0, o_ready}, 32'd1);
    step(1, 32'h108, 1, 0, 0);
    chk("bp4_pc", o_pc, 32'h108);
    step(0, 32'h0, 1, 0, 0);
    chk("bp5_occ", {30'd0, o_occ}, 32'd0);

    // stall
    step(1, 32'h20, 1, 0, 0);
    chk("st0_pc", o_pc, 32'h20);
    step(1, 32'h24, 1, 1, 0);
    chk("st1_occ", {30'd0, o_occ}, 32'd2);
    chk("st1_ready", {31'd0, o_ready}, 32'd0);
    step(1, 32'h28, 1, 1, 0);
    chk("st2_pc", o_pc, 32'h20);
    step(1, 32'h28, 1, 1, 0);
    chk("st3_pc", o_pc, 32'h20);
    step(1, 32'h28, 1, 0, 0);
    chk("st4_pc", o_pc, 32'h24);
    step(1, 32'h28, 1, 0, 0);
    chk("st5_pc", o_pc, 32'h28);
    step(0, 32'h0, 1, 0, 0);

    // flush with both entries held, stall active
    step(1, 32'h30, 0, 0, 0);
    step(1, 32'h34, 0, 0, 0);
    chk("fl0_occ", {30'd0, o_occ}, 32'd2);
    step(1, 32'h40, 0, 1, 1);
    chk("fl1_valid", {31'd0, o_valid}, 32'd0);
    chk("fl1_occ", {30'd0, o_occ}, 32'd0);
    chk("fl1_inst", o_inst, NOP);
    chk("fl1_pc", o_pc, 32'h30);
    // flush that coincides with an accepted transfer
    step(1, 32'h50, 1, 0, 0);
    chk("fl2_pc", o_pc, 32'h50);
    step(1, 32'h40, 1, 1, 1);
    chk("fl3_valid", {31'd0, o_valid}, 32'd0);
    chk("fl3_pc", o_pc, 32'h50);
    step(0, 32'h0, 1, 0, 0);
    chk("fl4_pc", o_pc, 32'h50);
    chk("fl4_valid", {31'd0, o_valid}, 32'd0);

`ifdef PIPELINE_DBG_EN
    step(1, 32'h0, 0, 0, 0);
    step(1, 32'h4, 0, 0, 0);
    chk("dbg0_tag", {29'd0, o_tag}, 32'd1);
    step(1, 32'h8, 1, 0, 0);
    chk("dbg1_tag", {29'd0, o_tag}, 32'd2);
    step(1, 32'h8, 1, 0, 0);
    chk("dbg2_tag", {29'd0, o_tag}, 32'd3);
    step(0, 32'h0, 0, 0, 1);
    chk("dbg3_tag", {29'd0, o_tag}, 32'd0);
`endif

    // asynchronous reset mid-cycle while two entries are held
    step(1, 32'h60, 0, 0, 0);
    step(1, 32'h64, 0, 0, 0);
    chk("rm0_occ", {30'd0, o_occ}, 32'd2);
    #2 rst = 1'b1;
    #1 chk_reset_vals("rst_mid");
    @(negedge clk);
    i_valid = 1'b0;
    rst = 1'b0;
    step(1, 32'h70, 1, 0, 0);
    chk("post_rst_pc", o_pc, 32'h70);
    step(0, 32'h0, 1, 0, 0);
    chk("post_rst_occ", {30'd0, o_occ}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
